// File: rtl/retire_trace_buf_if.sv
// Trace output stream: 32-bit beats, four per retired-instruction record.
interface retire_trace_buf_if;
    logic        tr_valid;
    logic        tr_ready;
    logic [31:0] tr_data;
    logic        tr_last;

    modport master (output tr_valid, output tr_data, output tr_last, input tr_ready);
    modport slave  (input tr_valid, input tr_data, input tr_last, output tr_ready);
endinterface

// File: rtl/retire_trace_buf.sv
// Retired-instruction trace FIFO with PC trigger/freeze; drains each record as four 32-bit beats.
module retire_trace_buf #(
    parameter int DEPTH     = 16,
    parameter int POST_TRIG = 4,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 ret_valid,
    input  logic [31:0]          ret_pc,
    input  logic [6:0]           ret_op,
    input  logic [2:0]           ret_funct3,
    input  logic                 ret_sub,
    input  logic [4:0]           ret_rd,
    input  logic                 ret_regwrite,
    input  logic                 ret_memtoreg,
    input  logic                 ret_dmem_we,
    input  logic [31:0]          ret_result,
    input  logic [31:0]          ret_dmem_addr,
    input  logic                 arm,
    input  logic                 trig_en,
    input  logic [31:0]          trig_pc,
    retire_trace_buf_if.master   tr,
    output logic                 frozen,
    output logic [CNT_W-1:0]     drop_cnt
);
    localparam int AW  = $clog2(DEPTH);
    localparam int PCW = $clog2(POST_TRIG + 2);

    typedef enum logic [1:0] {IDLE, ARMED, POST, FROZEN} state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ctl;
        logic [31:0] result;
        logic [31:0] addr;
    } rec_t;

    state_t         state, state_n;
    logic [PCW-1:0] post_cnt, post_cnt_n;
    logic [AW:0]    wr_ptr, rd_ptr;
    logic [1:0]     beat;
    rec_t           mem [DEPTH];
    rec_t           rec_in, head;
    logic           capturing, hit, empty, full, xfer, pop, push, drop;

    assign hit       = trig_en && (ret_pc == trig_pc);
    // arm takes priority over a same-cycle retire, so that record is never written
    assign capturing = ret_valid && !arm && (state == ARMED || state == POST);

    always_comb begin
        state_n    = state;
        post_cnt_n = post_cnt;
        if (arm) begin
            state_n    = ARMED;
            post_cnt_n = '0;
        end else begin
            case (state)
                ARMED: if (ret_valid && hit) begin
                    if (POST_TRIG == 0) begin
                        state_n = FROZEN;
                    end else begin
                        state_n    = POST;
                        post_cnt_n = PCW'(POST_TRIG);
                    end
                end
                POST: if (ret_valid) begin
                    post_cnt_n = post_cnt - PCW'(1);
                    if (post_cnt == PCW'(1)) state_n = FROZEN;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            post_cnt <= '0;
        end else begin
            state    <= state_n;
            post_cnt <= post_cnt_n;
        end
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign xfer  = tr.tr_valid && tr.tr_ready;
    assign pop   = xfer && (beat == 2'd3);
    // a final-beat pop frees the slot in time for a write into a full FIFO
    assign push  = capturing && (!full || pop);
    assign drop  = capturing && full && !pop;

    assign rec_in = '{pc: ret_pc,
                      ctl: {ret_op, ret_funct3, ret_sub, ret_rd, ret_regwrite,
                            ret_memtoreg, ret_dmem_we, 13'b0},
                      result: ret_result,
                      addr: ret_dmem_addr};

    always_ff @(posedge clk) begin
        if (!reset_n || arm) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            beat     <= '0;
            drop_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
            if (xfer) beat   <= beat + 2'd1;
            if (drop && !(&drop_cnt)) drop_cnt <= drop_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= rec_in;
    end

    assign head        = mem[rd_ptr[AW-1:0]];
    assign tr.tr_valid = !empty;
    assign tr.tr_last  = !empty && (beat == 2'd3);
    assign frozen      = (state == FROZEN);

    always_comb begin
        tr.tr_data = '0;
        if (!empty) begin
            case (beat)
                2'd0:    tr.tr_data = head.pc;
                2'd1:    tr.tr_data = head.ctl;
                2'd2:    tr.tr_data = head.result;
                default: tr.tr_data = head.addr;
            endcase
        end
    end
endmodule

// File: tb/tb_retire_trace_buf.sv
// Scoreboard bench for retire_trace_buf: directed retires push expected beats, a monitor pops them.
module tb_retire_trace_buf;
    logic        clk = 0;
    logic        reset_n = 0;
    logic        ret_valid = 0;
    logic [31:0] ret_pc = 0;
    logic [6:0]  ret_op = 0;
    logic [2:0]  ret_funct3 = 0;
    logic        ret_sub = 0;
    logic [4:0]  ret_rd = 0;
    logic        ret_regwrite = 0, ret_memtoreg = 0, ret_dmem_we = 0;
    logic [31:0] ret_result = 0, ret_dmem_addr = 0;
    logic        arm = 0, trig_en = 0;
    logic [31:0] trig_pc = 0;
    logic        frozen;
    logic [15:0] drop_cnt;

    retire_trace_buf_if tr_bus ();

    retire_trace_buf #(.DEPTH(16), .POST_TRIG(4), .CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .ret_valid(ret_valid), .ret_pc(ret_pc),
        .ret_op(ret_op), .ret_funct3(ret_funct3), .ret_sub(ret_sub), .ret_rd(ret_rd),
        .ret_regwrite(ret_regwrite), .ret_memtoreg(ret_memtoreg), .ret_dmem_we(ret_dmem_we),
        .ret_result(ret_result), .ret_dmem_addr(ret_dmem_addr), .arm(arm),
        .trig_en(trig_en), .trig_pc(trig_pc), .tr(tr_bus), .frozen(frozen), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    logic [32:0] exp_q [$];   // {last, data}

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Generic field pattern derived from the pc; expected control beat follows the record layout
    task automatic do_retire(input logic [31:0] pc, input bit expect_cap);
        logic [31:0] ctl;
        ret_pc = pc; ret_op = 7'b0110011; ret_funct3 = pc[4:2]; ret_sub = pc[2];
        ret_rd = pc[6:2]; ret_regwrite = 1'b1; ret_memtoreg = pc[3]; ret_dmem_we = pc[4];
        ret_result = pc ^ 32'hA5A5_0000; ret_dmem_addr = pc + 32'h1000;
        ctl = {7'b0110011, pc[4:2], pc[2], pc[6:2], 1'b1, pc[3], pc[4], 13'b0};
        if (expect_cap) begin
            exp_q.push_back({1'b0, pc});
            exp_q.push_back({1'b0, ctl});
            exp_q.push_back({1'b0, pc ^ 32'hA5A5_0000});
            exp_q.push_back({1'b1, pc + 32'h1000});
        end
        ret_valid = 1'b1;
        step();
        ret_valid = 1'b0;
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        step();
        arm = 1'b0;
    endtask

    task automatic drain_wait(input string name, input int max_cyc);
        int n = 0;
        while (exp_q.size() != 0 && n < max_cyc) begin
            step();
            n++;
        end
        chk(name, 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: compares each transferred beat and checks the held beat under backpressure
    initial begin
        logic        held_v = 1'b0;
        logic [32:0] held = '0;
        logic [32:0] got, want;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                held_v = 1'b0;
            end else begin
                got = {tr_bus.tr_last, tr_bus.tr_data};
                if (held_v && tr_bus.tr_valid) chk("stall_stable", 64'(got), 64'(held));
                if (tr_bus.tr_valid && tr_bus.tr_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", 64'(got), 64'h1_dead_beef);
                    end else begin
                        want = exp_q.pop_front();
                        chk("beat", 64'(got), 64'(want));
                    end
                end
                held_v = tr_bus.tr_valid && !tr_bus.tr_ready;
                held   = got;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tr_bus.tr_ready = 1'b1;
        // Reset with a retire asserted; then retires in IDLE must be ignored
        ret_valid = 1'b1; ret_pc = 32'h10;
        step(); step();
        chk("rst_valid", 64'(tr_bus.tr_valid), 64'd0);
        chk("rst_data", 64'(tr_bus.tr_data), 64'd0);
        chk("rst_last", 64'(tr_bus.tr_last), 64'd0);
        chk("rst_frozen", 64'(frozen), 64'd0);
        chk("rst_drop", 64'(drop_cnt), 64'd0);
        reset_n = 1'b1;
        step();
        ret_valid = 1'b0;
        step();
        chk("idle_no_capture", 64'(tr_bus.tr_valid), 64'd0);

        // Single ADDI x5 record, hand-packed control beat
        pulse_arm();
        ret_pc = 32'h10; ret_op = 7'b0010011; ret_funct3 = 3'b000; ret_sub = 1'b0;
        ret_rd = 5'd5; ret_regwrite = 1'b1; ret_memtoreg = 1'b0; ret_dmem_we = 1'b0;
        ret_result = 32'h7; ret_dmem_addr = 32'h0;
        exp_q.push_back({1'b0, 32'h0000_0010});
        exp_q.push_back({1'b0, 32'h2605_8000});
        exp_q.push_back({1'b0, 32'h0000_0007});
        exp_q.push_back({1'b1, 32'h0000_0000});
        ret_valid = 1'b1;
        step();
        ret_valid = 1'b0;
        chk("first_beat_latency", 64'(tr_bus.tr_valid), 64'd1);
        drain_wait("single_drain", 20);

        // Overflow: 20 retires into a stalled 16-deep FIFO
        tr_bus.tr_ready = 1'b0;
        pulse_arm();
        for (int i = 0; i < 20; i++) do_retire(32'h100 + 32'(i*4), i < 16);
        chk("overflow_drop", 64'(drop_cnt), 64'd4);
        tr_bus.tr_ready = 1'b1;
        drain_wait("overflow_drain", 100);

        // Arm mid-record while B2 is presented
        tr_bus.tr_ready = 1'b0;
        ret_pc = 32'h200;
        do_retire(32'h200, 1'b0);
        exp_q.push_back({1'b0, 32'h200});
        exp_q.push_back({1'b0, {7'b0110011, 3'b000, 1'b0, 5'b00000, 1'b1, 1'b0, 1'b0, 13'b0}});
        tr_bus.tr_ready = 1'b1;
        step(); step();
        tr_bus.tr_ready = 1'b0;
        chk("mid_b2_data", 64'(tr_bus.tr_data), 64'(32'h200 ^ 32'hA5A5_0000));
        chk("mid_drop_before", 64'(drop_cnt), 64'd4);
        pulse_arm();
        chk("mid_arm_valid", 64'(tr_bus.tr_valid), 64'd0);
        chk("mid_arm_drop", 64'(drop_cnt), 64'd0);
        chk("mid_arm_q", 64'(exp_q.size()), 64'd0);

        // Trigger at 0x40 with four post records; retire during arm is not captured
        tr_bus.tr_ready = 1'b1;
        trig_en = 1'b1; trig_pc = 32'h40;
        ret_valid = 1'b1; ret_pc = 32'h999;
        pulse_arm();
        ret_valid = 1'b0;
        chk("trig_not_frozen", 64'(frozen), 64'd0);
        for (logic [31:0] pc = 32'h30; pc <= 32'h70; pc += 32'd4) do_retire(pc, pc <= 32'h50);
        chk("trig_frozen", 64'(frozen), 64'd1);
        drain_wait("trig_drain", 100);
        chk("frozen_holds", 64'(frozen), 64'd1);

        // Backpressure: tr_ready toggles every cycle
        trig_en = 1'b0;
        tr_bus.tr_ready = 1'b0;
        pulse_arm();
        chk("arm_clears_frozen", 64'(frozen), 64'd0);
        for (int i = 0; i < 3; i++) do_retire(32'h300 + 32'(i*4), 1'b1);
        for (int n = 0; n < 100 && exp_q.size() != 0; n++) begin
            tr_bus.tr_ready = ~tr_bus.tr_ready;
            step();
        end
        chk("bp_drain", 64'(exp_q.size()), 64'd0);
        tr_bus.tr_ready = 1'b1;
        step(); step();
        chk("bp_idle_after", 64'(tr_bus.tr_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
